// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: owns the 128-bit state and round counter, time-sharing one external round datapath.
// Optional build macro AES_ROUND_CTRL_ABORT_EN adds an abort input that returns the FSM to IDLE.
module aes_round_ctrl #(
  parameter int NR    = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_block,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_block,
  output logic [3:0]       rk_addr,
  input  logic [127:0]     rk_data,
  output logic [127:0]     dp_in,
  output logic             dp_final,
  input  logic [127:0]     dp_out,
  output logic             busy,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [1:0] {IDLE, ADDKEY, ROUND, DONE} fsm_e;

  localparam logic [3:0] LAST_RND = 4'(NR);

  fsm_e             fsm_q;
  logic [127:0]     state_q;
  logic [3:0]       rnd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             abort_hit;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Abort only matters once a block is in flight; in IDLE a new block may still be accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= in_block;
            rnd_q   <= '0;
            fsm_q   <= ADDKEY;
          end
        end
        ADDKEY: begin
          if (abort_hit) begin
            rnd_q <= '0;
            fsm_q <= IDLE;
          end else begin
            state_q <= state_q ^ rk_data;
            rnd_q   <= 4'd1;
            fsm_q   <= ROUND;
          end
        end
        ROUND: begin
          if (abort_hit) begin
            rnd_q <= '0;
            fsm_q <= IDLE;
          end else begin
            state_q <= dp_out ^ rk_data;
            if (rnd_q == LAST_RND) begin
              fsm_q <= DONE;
            end else begin
              rnd_q <= rnd_q + 4'd1;
            end
          end
        end
        DONE: begin
          if (abort_hit) begin
            rnd_q <= '0;
            fsm_q <= IDLE;
          end else if (out_ready) begin
            cnt_q <= cnt_q + CNT_W'(1);
            fsm_q <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state so they settle with reset and never glitch on inputs.
  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q == ADDKEY) || (fsm_q == ROUND);
  assign rk_addr   = (fsm_q == ROUND) ? rnd_q : 4'd0;
  assign dp_final  = (fsm_q == ROUND) && (rnd_q == LAST_RND);
  assign dp_in     = state_q;
  assign out_block = state_q;
  assign blk_cnt   = cnt_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: models the AES-128 key store and round datapath,
// checks ciphertexts, round-key sequencing, handshakes, counters and reset/abort behaviour.
module tb_aes_round_ctrl;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready, in_ready2;
  logic [127:0] in_block;
  logic         out_valid, out_valid2;
  logic         out_ready;
  logic [127:0] out_block, out_block2;
  logic [3:0]   rk_addr, rk_addr2;
  logic [127:0] rk_data, rk_data2;
  logic [127:0] dp_in, dp_in2;
  logic         dp_final, dp_final2;
  logic [127:0] dp_out, dp_out2;
  logic         busy, busy2;
  logic [15:0]  blk_cnt;
  logic [1:0]   blk_cnt2;
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic         abort;
`endif

  int tests = 0;
  int fails = 0;
  logic [15:0]  exp_cnt;
  logic [7:0]   sbox [0:255];
  logic [127:0] rkeys [0:15];

  aes_round_ctrl #(.NR(10), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .rk_addr(rk_addr),
    .rk_data(rk_data), .dp_in(dp_in), .dp_final(dp_final), .dp_out(dp_out), .busy(busy),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort(abort),
`endif
    .blk_cnt(blk_cnt)
  );

  aes_round_ctrl #(.NR(10), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_block(in_block),
    .out_valid(out_valid2), .out_ready(out_ready), .out_block(out_block2), .rk_addr(rk_addr2),
    .rk_data(rk_data2), .dp_in(dp_in2), .dp_final(dp_final2), .dp_out(dp_out2), .busy(busy2),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort(abort),
`endif
    .blk_cnt(blk_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box derived from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    for (int r = 0; r < 16; r++) rkeys[r] = '0;
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic fin);
    logic [127:0] o;
    o = shift_rows(sub_bytes(s));
    if (!fin) o = mix_columns(o);
    return o;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rkeys[0];
    for (int r = 1; r <= 10; r++) begin
      s = shift_rows(sub_bytes(s));
      if (r != 10) s = mix_columns(s);
      s = s ^ rkeys[r];
    end
    return s;
  endfunction

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= 10) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         rkeys[r] = '0;
    end
  endtask

  assign rk_data  = rkeys[rk_addr];
  assign rk_data2 = rkeys[rk_addr2];
  always_comb dp_out  = round_fn(dp_in, dp_final);
  always_comb dp_out2 = round_fn(dp_in2, dp_final2);

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
`ifdef AES_ROUND_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    step();
    step();
    rst_n = 1'b1;
    exp_cnt = '0;
    step();
  endtask

  // Offers one block, waits for the accept edge, then counts cycles until out_valid (-1 on timeout).
  task automatic run_block(input logic [127:0] pt, output int lat, output logic [127:0] ct);
    int n;
    n = 0;
    in_block = pt;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    if (!out_valid) lat = -1;
    ct = out_block;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (rk_addr !== 4'd0) begin fails++; $display("[TB] FAIL reset_rk_addr: got %0d expected 0", rk_addr); end
    tests++; if (dp_final !== 1'b0) begin fails++; $display("[TB] FAIL reset_dp_final: got %b expected 0", dp_final); end
    tests++; if (blk_cnt !== 16'd0) begin fails++; $display("[TB] FAIL reset_blk_cnt: got %0d expected 0", blk_cnt); end
    tests++; if (out_block !== 128'h0) begin fails++; $display("[TB] FAIL reset_out_block: got %h expected 0", out_block); end
    step();
    step();
    rst_n = 1'b1;
    exp_cnt = '0;
    step();
  endtask

  task automatic test_fips();
    int lat;
    int n;
    logic [3:0] exp_rk;
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    out_ready = 1'b0;
    in_block = 128'h00112233445566778899aabbccddeeff;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    step();
    in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 14 && lat < 0; c++) begin
      if (out_valid) lat = c;
      else begin
        if (c <= 11) begin
          exp_rk = (c == 1) ? 4'd0 : 4'(c - 1);
          tests++; if (rk_addr !== exp_rk) begin fails++; $display("[TB] FAIL rk_seq cycle %0d: got %0d expected %0d", c, rk_addr, exp_rk); end
          tests++; if (dp_final !== (c == 11)) begin fails++; $display("[TB] FAIL dp_final cycle %0d: got %b expected %b", c, dp_final, c == 11); end
        end
        step();
      end
    end
    tests++; if (lat != 12) begin fails++; $display("[TB] FAIL fips_latency: got %0d expected 12", lat); end
    tests++; if (out_block !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin fails++; $display("[TB] FAIL fips_ct: got %h expected 69c4e0d86a7b0430d8cdb78070b4c55a", out_block); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_cnt++;
    tests++; if (blk_cnt !== 16'd1) begin fails++; $display("[TB] FAIL fips_blk_cnt: got %0d expected 1", blk_cnt); end
  endtask

  task automatic test_random_blocks();
    int lat;
    logic [127:0] pt, ct, exp;
    for (int k = 0; k < 4; k++) begin
      load_key(rand128());
      pt = rand128();
      exp = aes_encrypt(pt);
      out_ready = 1'b1;
      run_block(pt, lat, ct);
      tests++; if (ct !== exp) begin fails++; $display("[TB] FAIL rand_ct %0d: got %h expected %h", k, ct, exp); end
      tests++; if (lat != 12) begin fails++; $display("[TB] FAIL rand_latency %0d: got %0d expected 12", k, lat); end
      step();
      out_ready = 1'b0;
      exp_cnt++;
      tests++; if (blk_cnt !== exp_cnt) begin fails++; $display("[TB] FAIL rand_blk_cnt %0d: got %0d expected %0d", k, blk_cnt, exp_cnt); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [127:0] pt, ct, exp;
    load_key(rand128());
    pt = rand128();
    exp = aes_encrypt(pt);
    out_ready = 1'b0;
    run_block(pt, lat, ct);
    in_block = rand128();
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tests++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_out_valid cycle %0d: got %b expected 1", c, out_valid); end
      tests++; if (out_block !== exp) begin fails++; $display("[TB] FAIL bp_out_block cycle %0d: got %h expected %h", c, out_block, exp); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_in_ready cycle %0d: got %b expected 0", c, in_ready); end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_cnt++;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL bp_release_idle: got %b expected 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_release_valid: got %b expected 0", out_valid); end
    tests++; if (blk_cnt !== exp_cnt) begin fails++; $display("[TB] FAIL bp_blk_cnt: got %0d expected %0d", blk_cnt, exp_cnt); end
    step();
    tests++; if (blk_cnt !== exp_cnt) begin fails++; $display("[TB] FAIL bp_blk_cnt_once: got %0d expected %0d", blk_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp_q [$];
    int acc_cyc [$];
    int done, nacc, cyc;
    logic hs, acc;
    logic [127:0] exp;
    apply_reset();
    load_key(rand128());
    done = 0;
    nacc = 0;
    cyc = 0;
    out_ready = 1'b1;
    in_block = rand128();
    in_valid = 1'b1;
    while (done < 5 && cyc < 200) begin
      tests++; if (blk_cnt !== exp_cnt) begin fails++; $display("[TB] FAIL b2b_blk_cnt cycle %0d: got %0d expected %0d", cyc, blk_cnt, exp_cnt); end
      tests++; if (blk_cnt2 !== exp_cnt[1:0]) begin fails++; $display("[TB] FAIL b2b_blk_cnt_w2 cycle %0d: got %0d expected %0d", cyc, blk_cnt2, exp_cnt[1:0]); end
      hs  = out_valid && out_ready;
      acc = in_valid && in_ready;
      if (hs) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'h0;
        tests++; if (out_block !== exp) begin fails++; $display("[TB] FAIL b2b_ct %0d: got %h expected %h", done, out_block, exp); end
        tests++; if (out_block2 !== exp) begin fails++; $display("[TB] FAIL b2b_ct_w2 %0d: got %h expected %h", done, out_block2, exp); end
      end
      if (acc) begin
        acc_cyc.push_back(cyc);
        exp_q.push_back(aes_encrypt(in_block));
      end
      step();
      cyc++;
      if (hs) begin
        exp_cnt++;
        done++;
        if (done == 3) begin
          tests++; if (blk_cnt !== 16'd3) begin fails++; $display("[TB] FAIL b2b_three_blocks: got %0d expected 3", blk_cnt); end
        end
      end
      if (acc) begin
        nacc++;
        if (nacc == 5) in_valid = 1'b0;
        else in_block = rand128();
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    tests++; if (done != 5) begin fails++; $display("[TB] FAIL b2b_timeout: got %0d blocks expected 5", done); end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      tests++; if (acc_cyc[i] - acc_cyc[i-1] != 13) begin fails++; $display("[TB] FAIL b2b_spacing %0d: got %0d expected 13", i, acc_cyc[i] - acc_cyc[i-1]); end
    end
    tests++; if (blk_cnt !== 16'd5) begin fails++; $display("[TB] FAIL b2b_final_cnt: got %0d expected 5", blk_cnt); end
    tests++; if (blk_cnt2 !== 2'd1) begin fails++; $display("[TB] FAIL b2b_wrap_cnt: got %0d expected 1", blk_cnt2); end
  endtask

  task automatic test_reset_mid_round();
    int n, lat;
    logic [127:0] pt, ct, exp;
    load_key(rand128());
    out_ready = 1'b0;
    in_block = rand128();
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    step();
    in_valid = 1'b0;
    n = 0;
    while (!(busy && rk_addr == 4'd5) && n < 20) begin step(); n++; end
    tests++; if (!(busy && rk_addr == 4'd5)) begin fails++; $display("[TB] FAIL midrst_reach_rnd5: got rk_addr %0d busy %b expected 5 1", rk_addr, busy); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL midrst_in_ready: got %b expected 1", in_ready); end
    tests++; if (rk_addr !== 4'd0) begin fails++; $display("[TB] FAIL midrst_rk_addr: got %0d expected 0", rk_addr); end
    tests++; if (out_block !== 128'h0) begin fails++; $display("[TB] FAIL midrst_state: got %h expected 0", out_block); end
    tests++; if (blk_cnt !== 16'd0) begin fails++; $display("[TB] FAIL midrst_blk_cnt: got %0d expected 0", blk_cnt); end
    step();
    rst_n = 1'b1;
    exp_cnt = '0;
    step();
    pt = rand128();
    exp = aes_encrypt(pt);
    out_ready = 1'b1;
    run_block(pt, lat, ct);
    tests++; if (ct !== exp) begin fails++; $display("[TB] FAIL midrst_next_ct: got %h expected %h", ct, exp); end
    step();
    out_ready = 1'b0;
    exp_cnt++;
    tests++; if (blk_cnt !== exp_cnt) begin fails++; $display("[TB] FAIL midrst_next_cnt: got %0d expected %0d", blk_cnt, exp_cnt); end
  endtask

`ifdef AES_ROUND_CTRL_ABORT_EN
  task automatic test_abort();
    int n, lat, seen;
    logic [127:0] pt, ct, exp;
    load_key(rand128());
    out_ready = 1'b1;
    in_block = rand128();
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    step();
    in_valid = 1'b0;
    n = 0;
    while (!(busy && rk_addr == 4'd4) && n < 20) begin step(); n++; end
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests++; if (in_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_idle: got in_ready %b busy %b expected 1 0", in_ready, busy); end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) seen++;
      step();
    end
    tests++; if (seen != 0) begin fails++; $display("[TB] FAIL abort_no_valid: got %0d valid cycles expected 0", seen); end
    tests++; if (blk_cnt !== exp_cnt) begin fails++; $display("[TB] FAIL abort_cnt: got %0d expected %0d", blk_cnt, exp_cnt); end
    pt = rand128();
    exp = aes_encrypt(pt);
    out_ready = 1'b0;
    run_block(pt, lat, ct);
    abort = 1'b1;
    out_ready = 1'b1;
    step();
    abort = 1'b0;
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL abort_done_valid: got %b expected 0", out_valid); end
    tests++; if (blk_cnt !== exp_cnt) begin fails++; $display("[TB] FAIL abort_done_cnt: got %0d expected %0d", blk_cnt, exp_cnt); end
    tests++; if (out_block !== exp) begin fails++; $display("[TB] FAIL abort_state_kept: got %h expected %h", out_block, exp); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_block = '0;
    exp_cnt = '0;
`ifdef AES_ROUND_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    build_sbox();
    test_reset();
    test_fips();
    test_random_blocks();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_round();
`ifdef AES_ROUND_CTRL_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Iterative AES encryption round sequencer. It owns the 128-bit state register and round counter. Each cycle it drives one shared round datapath (SubBytes/ShiftRows/MixColumns, external, combinational) and selects the round key from an external key store. It XORs in the round key and returns the ciphertext through a valid/ready handshake. It sits between the block I/O interface and the single-instance round logic, so the MixColumns hardware is time-shared across all rounds.

Parameters:
NR, 10, number of rounds (10/12/14 for AES-128/192/256); legal range 1..15
CNT_W, 16, width of completed-block counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  plaintext block offered
in_ready  output  1  controller can accept a block
in_block  input  128  plaintext, byte 0 in [127:120]
out_valid  output  1  ciphertext available
out_ready  input  1  consumer accepts ciphertext
out_block  output  128  ciphertext (state register)
rk_addr  output  4  round-key index into key store
rk_data  input  128  round key for rk_addr, same-cycle (combinational read)
dp_in  output  128  state presented to round datapath
dp_final  output  1  1 = final round, datapath must skip MixColumns
dp_out  input  128  datapath result, combinational from dp_in/dp_final
busy  output  1  high in ADDKEY or ROUND
blk_cnt  output  CNT_W  completed blocks, wraps

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, state=0, rnd=0, blk_cnt=0, out_valid=0, in_ready=1, busy=0, rk_addr=0, dp_final=0.
- FSM states: IDLE, ADDKEY, ROUND, DONE. All outputs are decoded from registered state/rnd.
- IDLE: in_ready=1. On in_valid&in_ready: state<=in_block, rnd<=0, go ADDKEY. Otherwise hold.
- ADDKEY (1 cycle): rk_addr=0; state<=state^rk_data; rnd<=1; go ROUND.
- ROUND: dp_in=state; rk_addr=rnd; dp_final=(rnd==NR); state<=dp_out^rk_data.
  - If rnd==NR: go DONE.
  - Else: rnd<=rnd+1.
- DONE: out_valid=1, out_block=state.
  - On out_ready: blk_cnt<=blk_cnt+1 (mod 2^CNT_W), go IDLE.
  - Without out_ready: out_valid and out_block stay stable indefinitely.
- Latency: accept edge at cycle 0 -> out_valid high in cycle NR+2 (12 for NR=10). Throughput is one block per NR+3 cycles with out_ready held high.
- in_ready=0 in ADDKEY, ROUND and DONE. in_valid is ignored there; the upstream source must hold its block.
- In IDLE: rk_addr=0, dp_final=0, dp_in=state. Outputs in non-ROUND states are don't-care to the datapath, but must be driven (no X).
- out_block reflects the state register at all times. It is valid only when out_valid=1.
- rnd is 4 bits and never exceeds NR. blk_cnt wraps from all-ones to 0 without a flag.
- Asynchronous reset mid-operation aborts immediately. The partially processed block is discarded, with no output.

Optional Feature:
AES_ROUND_CTRL_ABORT_EN
- Defined: adds input abort (1 bit). When abort=1 at a clock edge in ADDKEY, ROUND or DONE, the FSM goes to IDLE and rnd<=0. state is preserved and blk_cnt is not incremented. out_valid drops the next cycle. abort wins over a simultaneous out_ready in DONE. abort in IDLE is ignored, and a simultaneous in_valid is still accepted.
- Undefined: no abort port exists, and behaviour is exactly as above.

Test Plan:
- FIPS-197 C.1: bench models the key store (AES-128 expansion of key 000102030405060708090a0b0c0d0e0f) and the round datapath. Apply plaintext 00112233445566778899aabbccddeeff -> out_block=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid rises exactly 12 cycles after the accept edge, blk_cnt=1.
- Back-pressure: hold out_ready=0 for 20 cycles in DONE -> out_valid and out_block stable, in_ready=0, and a second in_valid is not accepted. Release -> IDLE next cycle, blk_cnt increments once.
- Round-key sequencing: monitor rk_addr/dp_final -> sequence 0 (ADDKEY), then 1..10 in ROUND, with dp_final=1 only in the rnd=10 cycle.
- Back-to-back: 3 blocks with in_valid and out_ready tied high -> accepts spaced 13 cycles apart, correct ciphertexts, blk_cnt=3. With CNT_W=2 and 5 blocks -> blk_cnt=1 (wrap).
- Reset mid-round: drop rst_n in ROUND with rnd=5 -> outputs take reset values asynchronously (before next edge). After release, the next block encrypts correctly.
- With AES_ROUND_CTRL_ABORT_EN: assert abort at rnd=4 -> IDLE next cycle, no out_valid, blk_cnt unchanged. Abort together with out_ready in DONE -> blk_cnt unchanged.
